pipeline_stage_reg: RTL
=======================

Name: pipeline_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the RISC-V pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the fixed-field stage registers. Adds:
  - a valid/ready handshake;
  - a 2-entry skid buffer, so ready does not propagate combinationally upstream;
  - a global stall input (memory busy-wait);
  - a flush input that inserts a bubble;
  - a configurable reset PC value.
- Control, data and PC fields are passed as packed vectors.

Parameters:
- CTRL_WIDTH, 24, width of the packed control field (branch, reg-write, mem-read/write, ALU op, ...).
- DATA_WIDTH, 128, width of the packed data field (operands, immediate, register addresses).
- CTRL_BUBBLE, 0, control value presented whenever the output is not valid, and after flush or reset.
- PC_RESET, 32'hFFFF_FFFC, OUT_PC value after reset (-4).
- SKID_ENABLE, 1:
  - 1 selects the 2-entry skid buffer with registered IN_READY;
  - 0 selects a single entry with combinational IN_READY.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- STALL  in  1  global freeze (data-memory or instruction-memory busy-wait).
- FLUSH  in  1  kill all held and incoming entries (branch or jump taken).
- IN_VALID  in  1  upstream has an entry.
- IN_READY  out  1  stage can accept an entry.
- IN_CTRL  in  CTRL_WIDTH  control field.
- IN_DATA  in  DATA_WIDTH  data field.
- IN_PC  in  32  PC+4 of the entry.
- OUT_VALID  out  1  head entry is valid.
- OUT_READY  in  1  downstream accepts the head entry.
- OUT_CTRL  out  CTRL_WIDTH  head control field, or CTRL_BUBBLE when OUT_VALID=0.
- OUT_DATA  out  DATA_WIDTH  head data field.
- OUT_PC  out  32  head PC+4.
- OCCUPANCY  out  2  number of held entries (0..2).

Behaviour:

Reset
- RESET sampled low at a rising edge sets: OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, OUT_DATA=0, OUT_PC=PC_RESET, OCCUPANCY=0, IN_READY=1, and clears the skid entry.
- No transfer completes in a cycle where RESET=0.
- Reset has priority over FLUSH and STALL, and aborts any held entries mid-operation.

Transfer definitions
- Push = IN_VALID & IN_READY & !STALL & !FLUSH.
- Pop = OUT_VALID & OUT_READY & !STALL.

Priority
- Order is RESET > FLUSH > STALL > normal operation.

FLUSH
- Next state: OCCUPANCY=0, OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, IN_READY=1.
- The incoming entry in that cycle is discarded.
- OUT_DATA and OUT_PC hold their previous values.
- FLUSH during STALL still flushes.

STALL
- All registers hold, including IN_READY. Neither push nor pop occurs.

States (SKID_ENABLE=1)
- EMPTY (occupancy 0):
  - push -> ONE, with the head loaded from the inputs.
- ONE (occupancy 1):
  - push without pop -> FULL, with the skid entry loaded.
  - push with pop -> ONE, with the head replaced by the inputs.
  - pop without push -> EMPTY.
  - neither -> hold.
- FULL (occupancy 2):
  - pop -> ONE, with skid moving to head.
  - no push is possible, because IN_READY=0.
- IN_READY is registered: next IN_READY = (next state != FULL).
- There is no combinational path from OUT_READY to IN_READY.
- Ordering is strictly FIFO. Latency is 1 cycle from push to OUT_VALID when the stage is empty.
- A single entry is never duplicated or dropped, except by FLUSH or RESET.

SKID_ENABLE=0
- IN_READY = !OUT_VALID | OUT_READY, qualified by !STALL. This is a combinational path.
- States are EMPTY and ONE only. Simultaneous push and pop replaces the head.
- OCCUPANCY is at most 1.

Output rules
- OUT_CTRL is muxed to CTRL_BUBBLE whenever OUT_VALID=0.
- This keeps downstream stages that ignore OUT_VALID safe (no spurious reg-write or mem-write).
- All outputs change only after the clock edge. There are no level-triggered updates.

Test Plan:
- Reset: hold RESET=0 for 2 cycles with IN_VALID=1, then release -> OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, OUT_PC=32'hFFFF_FFFC, OCCUPANCY=0, IN_READY=1; the first push after release appears as OUT_VALID=1 one cycle later.
- Streaming: OUT_READY=1 held, push entries with IN_PC=4,8,12,16 on consecutive cycles -> OUT_PC shows 4,8,12,16 on the following consecutive cycles, OCCUPANCY stays 1, and there are no gaps.
- Backpressure: OUT_READY=0, push PC=4,8,12 -> after 2 pushes OCCUPANCY=2 and IN_READY=0, and PC=12 is not accepted; raise OUT_READY -> outputs 4 then 8, IN_READY returns to 1, and PC=12 is accepted afterwards.
- Stall: OCCUPANCY=1 (PC=20), assert STALL for 3 cycles with IN_VALID=1 and OUT_READY=1 -> all outputs are frozen and no push or pop occurs; after release, PC=20 pops on the next edge.
- Flush: OCCUPANCY=2 (PC=4,8) plus an incoming PC=12, FLUSH=1 for one cycle -> next cycle OUT_VALID=0, OUT_CTRL=CTRL_BUBBLE, OCCUPANCY=0, and PC=12 never appears; flush asserted during STALL produces the same result.
- Bypass mode: with SKID_ENABLE=0, OUT_VALID=1 and OUT_READY=0 -> IN_READY=0 in the same cycle; OUT_READY=1 with a push -> the head is replaced and OCCUPANCY stays 1.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, global stall, bubble-inserting flush and configurable reset PC.
module pipeline_stage_reg #(
    parameter int unsigned           CTRL_WIDTH  = 24,
    parameter int unsigned           DATA_WIDTH  = 128,
    parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0,
    parameter logic [31:0]           PC_RESET    = 32'hFFFF_FFFC,
    parameter bit                    SKID_ENABLE = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  STALL,
    input  logic                  FLUSH,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [CTRL_WIDTH-1:0] IN_CTRL,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic [31:0]           IN_PC,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [CTRL_WIDTH-1:0] OUT_CTRL,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [31:0]           OUT_PC,
    output logic [1:0]            OCCUPANCY
);

    // Handshake: an entry moves when valid and ready are both high at a rising
    // edge with STALL low (and FLUSH low on the input side); neither side may
    // make valid depend on ready.

    // State encoding equals the number of held entries, so OCCUPANCY is the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_in_ready;
    logic                    w_in_ready_nxt;

    logic [CTRL_WIDTH-1:0]   r_head_ctrl;
    logic [DATA_WIDTH-1:0]   r_head_data;
    logic [31:0]             r_head_pc;
    logic [CTRL_WIDTH-1:0]   r_skid_ctrl;
    logic [DATA_WIDTH-1:0]   r_skid_data;
    logic [31:0]             r_skid_pc;

    logic [CTRL_WIDTH-1:0]   w_head_ctrl_nxt;
    logic [DATA_WIDTH-1:0]   w_head_data_nxt;
    logic [31:0]             w_head_pc_nxt;
    logic [CTRL_WIDTH-1:0]   w_skid_ctrl_nxt;
    logic [DATA_WIDTH-1:0]   w_skid_data_nxt;
    logic [31:0]             w_skid_pc_nxt;

    logic                    w_out_valid;
    logic                    w_in_ready;
    logic                    w_push;
    logic                    w_pop;

    assign w_out_valid = (r_state != ST_EMPTY);

    // Without the skid entry, ready is taken straight from the downstream side.
    assign w_in_ready = SKID_ENABLE ? r_in_ready
                                    : ((!w_out_valid || OUT_READY) && !STALL);

    assign w_push = IN_VALID && w_in_ready && !STALL && !FLUSH;
    assign w_pop  = w_out_valid && OUT_READY && !STALL;

    always_comb begin
        w_state_nxt     = r_state;
        w_head_ctrl_nxt = r_head_ctrl;
        w_head_data_nxt = r_head_data;
        w_head_pc_nxt   = r_head_pc;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_skid_pc_nxt   = r_skid_pc;

        if (FLUSH) begin
            w_state_nxt = ST_EMPTY;
        end else if (!STALL) begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_head_ctrl_nxt = IN_CTRL;
                        w_head_data_nxt = IN_DATA;
                        w_head_pc_nxt   = IN_PC;
                        w_state_nxt     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_head_ctrl_nxt = IN_CTRL;
                        w_head_data_nxt = IN_DATA;
                        w_head_pc_nxt   = IN_PC;
                    end else if (w_push && SKID_ENABLE) begin
                        w_skid_ctrl_nxt = IN_CTRL;
                        w_skid_data_nxt = IN_DATA;
                        w_skid_pc_nxt   = IN_PC;
                        w_state_nxt     = ST_FULL;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_head_ctrl_nxt = r_skid_ctrl;
                        w_head_data_nxt = r_skid_data;
                        w_head_pc_nxt   = r_skid_pc;
                        w_state_nxt     = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end

        w_in_ready_nxt = (w_state_nxt != ST_FULL);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_head_ctrl <= CTRL_BUBBLE;
            r_head_data <= '0;
            r_head_pc   <= PC_RESET;
            r_skid_ctrl <= CTRL_BUBBLE;
            r_skid_data <= '0;
            r_skid_pc   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_head_ctrl <= w_head_ctrl_nxt;
            r_head_data <= w_head_data_nxt;
            r_head_pc   <= w_head_pc_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
        end
    end

    // Bubble control keeps downstream stages that ignore OUT_VALID from writing.
    assign IN_READY  = w_in_ready;
    assign OUT_VALID = w_out_valid;
    assign OUT_CTRL  = w_out_valid ? r_head_ctrl : CTRL_BUBBLE;
    assign OUT_DATA  = r_head_data;
    assign OUT_PC    = r_head_pc;
    assign OCCUPANCY = r_state;

endmodule
